// File: rtl/rans_encoder_p_pkg.sv
// Shared definitions for the rANS encoder/decoder pair: FSM encoding, default geometry, legality check.
// No logic of its own; imported by the coder and the sequential divider.
package rans_encoder_p_pkg;

    localparam int DEF_SYM_W     = 4;
    localparam int DEF_STATE_W   = 16;
    localparam int DEF_PROB_BITS = 8;
    localparam int DEF_L         = 1 << (DEF_STATE_W - DEF_SYM_W);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RENORM,
        ST_EMIT,
        ST_DIVIDE,
        ST_UPDATE,
        ST_FLUSH
    } state_e;

    // Geometry must keep the renormalised state in [L, 2^STATE_W) and f in 1..M.
    function automatic bit params_legal(int sym_w, int state_w, int prob_bits, int cnt_w);
        return (sym_w > 0) && (prob_bits > 0) && (state_w % sym_w == 0) &&
               (prob_bits <= state_w - sym_w) && (cnt_w == prob_bits + 1);
    endfunction

endpackage

// File: rtl/rans_seq_divider.sv
// Restoring divider, one quotient bit per enabled cycle; start performs the first step, done pulses when results are valid.
// Latency W cycles from start to done; no backpressure, results hold until the next start.
module rans_seq_divider #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         ena,
    input  logic         start,
    input  logic [W-1:0] dividend,
    input  logic [W-1:0] divisor,
    output logic         done,
    output logic [W-1:0] quotient,
    output logic [W-1:0] remainder
);

    localparam int CW = $clog2(W + 1);

    logic [CW-1:0] cnt_q;
    logic [W-1:0]  dsr_q;
    logic [W-1:0]  src_rem;
    logic [W-1:0]  src_quo;
    logic [W-1:0]  src_dsr;
    logic [W:0]    shifted;
    logic [W:0]    diff;

    // The quotient register doubles as the dividend shifter, so start feeds the raw operands straight in.
    always_comb begin
        src_rem = start ? '0 : remainder;
        src_quo = start ? dividend : quotient;
        src_dsr = start ? divisor : dsr_q;
        shifted = {src_rem, src_quo[W-1]};
        diff    = shifted - {1'b0, src_dsr};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q     <= '0;
            dsr_q     <= '0;
            quotient  <= '0;
            remainder <= '0;
            done      <= 1'b0;
        end else if (ena) begin
            done <= 1'b0;
            if (start || (cnt_q != '0)) begin
                quotient  <= {src_quo[W-2:0], ~diff[W]};
                remainder <= diff[W] ? shifted[W-1:0] : diff[W-1:0];
            end
            if (start) begin
                dsr_q <= divisor;
                cnt_q <= CW'(W - 1);
            end else if (cnt_q != '0) begin
                cnt_q <= cnt_q - CW'(1);
                done  <= (cnt_q == CW'(1));
            end
        end
    end

endmodule

// File: rtl/rans_encoder_p.sv
// rANS encoder: renormalise by emitting SYM_W-bit words, then x' = (x/f)*M + x%f + c; flush streams the final state.
// Latency STATE_W+2 cycles per symbol plus RENORM+EMIT time per word; out holds stable while out_rdy is low.
module rans_encoder_p
    import rans_encoder_p_pkg::*;
#(
    parameter int SYM_W     = DEF_SYM_W,
    parameter int STATE_W   = DEF_STATE_W,
    parameter int PROB_BITS = DEF_PROB_BITS,
    parameter int CNT_W     = PROB_BITS + 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 ena,
    input  logic [CNT_W-1:0]     s_count,
    input  logic [PROB_BITS-1:0] s_cumulative,
    input  logic                 in_vld,
    output logic                 in_rdy,
    input  logic                 flush,
    output logic [SYM_W-1:0]     out,
    output logic                 out_vld,
    input  logic                 out_rdy,
    output logic                 out_last,
    output logic                 busy,
    output logic                 err
);

    localparam int NWORDS = STATE_W / SYM_W;
    localparam int WCNT_W = $clog2(NWORDS + 1);
    localparam logic [STATE_W-1:0] X_L       = {{(SYM_W - 1){1'b0}}, 1'b1, {(STATE_W - SYM_W){1'b0}}};
    localparam logic [STATE_W:0]   L_EXT     = {1'b0, X_L};
    localparam logic [STATE_W:0]   XMAX_UNIT = (L_EXT >> PROB_BITS) << SYM_W;

    state_e               state_q;
    logic [STATE_W-1:0]   x_q;
    logic [CNT_W-1:0]     f_q;
    logic [PROB_BITS-1:0] c_q;
    logic [WCNT_W-1:0]    wcnt_q;

    logic [STATE_W:0]     f_ext;
    logic [STATE_W:0]     x_max;
    logic                 x_ge;
    logic [STATE_W-1:0]   x_shift;
    logic [STATE_W-1:0]   x_upd;
    logic                 div_start;
    logic                 div_done;
    logic [STATE_W-1:0]   div_q;
    logic [STATE_W-1:0]   div_r;

    // x_max needs one extra bit: at f=M it equals 2^STATE_W, so no state can ever reach it.
    always_comb begin
        f_ext   = {{(STATE_W + 1 - CNT_W){1'b0}}, f_q};
        x_max   = XMAX_UNIT * f_ext;
        x_ge    = ({1'b0, x_q} >= x_max);
        x_shift = x_q >> SYM_W;
        x_upd   = div_q << PROB_BITS;
        x_upd   = x_upd + div_r + {{(STATE_W - PROB_BITS){1'b0}}, c_q};
    end

    assign div_start = ena && (state_q == ST_RENORM) && !x_ge;

    rans_seq_divider #(
        .W(STATE_W)
    ) u_div (
        .clk       (clk),
        .rst_n     (rst_n),
        .ena       (ena),
        .start     (div_start),
        .dividend  (x_q),
        .divisor   ({{(STATE_W - CNT_W){1'b0}}, f_q}),
        .done      (div_done),
        .quotient  (div_q),
        .remainder (div_r)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            x_q      <= X_L;
            f_q      <= '0;
            c_q      <= '0;
            wcnt_q   <= '0;
            in_rdy   <= 1'b1;
            out      <= '0;
            out_vld  <= 1'b0;
            out_last <= 1'b0;
            busy     <= 1'b0;
            err      <= 1'b0;
        end else if (ena) begin
            case (state_q)
                ST_IDLE: begin
                    if (flush) begin
                        state_q  <= ST_FLUSH;
                        wcnt_q   <= WCNT_W'(NWORDS);
                        out      <= x_q[SYM_W-1:0];
                        out_vld  <= 1'b1;
                        out_last <= (NWORDS == 1);
                        in_rdy   <= 1'b0;
                        busy     <= 1'b1;
                    end else if (in_vld && in_rdy) begin
                        f_q <= s_count;
                        c_q <= s_cumulative;
                        // A zero-frequency symbol cannot be coded; flag it and stay ready.
                        if (s_count == '0) begin
                            err <= 1'b1;
                        end else begin
                            state_q <= ST_RENORM;
                            in_rdy  <= 1'b0;
                            busy    <= 1'b1;
                        end
                    end
                end
                ST_RENORM: begin
                    if (x_ge) begin
                        state_q <= ST_EMIT;
                        out     <= x_q[SYM_W-1:0];
                        out_vld <= 1'b1;
                    end else begin
                        state_q <= ST_DIVIDE;
                    end
                end
                ST_EMIT: begin
                    if (out_rdy) begin
                        out_vld <= 1'b0;
                        x_q     <= x_shift;
                        state_q <= ST_RENORM;
                    end
                end
                ST_DIVIDE: begin
                    if (div_done) begin
                        state_q <= ST_UPDATE;
                    end
                end
                ST_UPDATE: begin
                    x_q     <= x_upd;
                    in_rdy  <= 1'b1;
                    busy    <= 1'b0;
                    state_q <= ST_IDLE;
                end
                ST_FLUSH: begin
                    if (out_rdy) begin
                        if (wcnt_q == WCNT_W'(1)) begin
                            x_q      <= X_L;
                            out_vld  <= 1'b0;
                            out_last <= 1'b0;
                            in_rdy   <= 1'b1;
                            busy     <= 1'b0;
                            state_q  <= ST_IDLE;
                        end else begin
                            x_q      <= x_shift;
                            out      <= x_shift[SYM_W-1:0];
                            out_last <= (wcnt_q == WCNT_W'(2));
                            wcnt_q   <= wcnt_q - WCNT_W'(1);
                        end
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    param_legal_a: assert property (@(posedge clk) params_legal(SYM_W, STATE_W, PROB_BITS, CNT_W));

endmodule

// File: tb/tb_rans_encoder_p.sv
// Randomised and directed bench for rans_encoder_p against an arithmetic rANS model.
// The model state is observed through the flush word stream.
module tb_rans_encoder_p;

    localparam int SYM_W     = 4;
    localparam int STATE_W   = 16;
    localparam int PROB_BITS = 8;
    localparam int CNT_W     = PROB_BITS + 1;
    localparam int M         = 1 << PROB_BITS;
    localparam int L         = 1 << (STATE_W - SYM_W);
    localparam int NW        = STATE_W / SYM_W;
    localparam int BOUND     = 3000;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic                 ena = 1'b1;
    logic [CNT_W-1:0]     s_count = '0;
    logic [PROB_BITS-1:0] s_cumulative = '0;
    logic                 in_vld = 1'b0;
    logic                 in_rdy;
    logic                 flush = 1'b0;
    logic [SYM_W-1:0]     out;
    logic                 out_vld;
    logic                 out_rdy = 1'b0;
    logic                 out_last;
    logic                 busy;
    logic                 err;

    int n_cmp = 0;
    int n_bad = 0;
    int mx = L;
    bit m_err = 1'b0;
    int exp_q[$];
    int flush_got[$];

    always #5 clk = ~clk;

    rans_encoder_p #(
        .SYM_W(SYM_W), .STATE_W(STATE_W), .PROB_BITS(PROB_BITS), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst_n(rst_n), .ena(ena), .s_count(s_count), .s_cumulative(s_cumulative),
        .in_vld(in_vld), .in_rdy(in_rdy), .flush(flush), .out(out), .out_vld(out_vld),
        .out_rdy(out_rdy), .out_last(out_last), .busy(busy), .err(err)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference coder: emit low words while x >= x_max, then apply the state update.
    function automatic void model_symbol(int f, int c);
        exp_q.delete();
        if (f == 0) begin
            m_err = 1'b1;
            return;
        end
        while (mx >= ((L >> PROB_BITS) << SYM_W) * f) begin
            exp_q.push_back(mx % (1 << SYM_W));
            mx = mx / (1 << SYM_W);
        end
        mx = (mx / f) * M + (mx % f) + c;
    endfunction

    task automatic check_reset(input string tag);
        chk({tag, "_in_rdy"}, in_rdy, 1);
        chk({tag, "_out_vld"}, out_vld, 0);
        chk({tag, "_out"}, out, 0);
        chk({tag, "_out_last"}, out_last, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_err"}, err, 0);
    endtask

    // rdy_mode: 0 always ready, 1 first word held off 5 cycles, 2 random; ena drops 3 cycles from ena_at.
    task automatic send(input int f, input int c, input int rdy_mode, input int ena_at);
        int cyc = 0;
        int emit_cyc = 0;
        int ena_low = 0;
        int hold;
        int got[$];
        logic [SYM_W-1:0] prev_out = '0;
        bit prev_stall = 1'b0;
        model_symbol(f, c);
        @(negedge clk);
        chk("rdy_before_sym", in_rdy, 1);
        s_count = CNT_W'(f);
        s_cumulative = PROB_BITS'(c);
        in_vld = 1'b1;
        out_rdy = 1'b0;
        @(negedge clk);
        in_vld = 1'b0;
        if (f == 0) begin
            chk("err_f0", err, 1);
            chk("rdy_f0", in_rdy, 1);
            chk("vld_f0", out_vld, 0);
            chk("busy_f0", busy, 0);
            return;
        end
        chk("busy_run", busy, 1);
        hold = (rdy_mode == 1) ? 5 : 0;
        while (!in_rdy && cyc < BOUND) begin
            ena = !(ena_at > 0 && cyc >= ena_at && cyc < ena_at + 3);
            if (!ena) ena_low++;
            if (out_vld) begin
                emit_cyc++;
                if (prev_stall) chk("out_hold", out, prev_out);
                case (rdy_mode)
                    0: out_rdy = 1'b1;
                    1: begin
                        out_rdy = (hold == 0);
                        if (hold > 0) hold--;
                    end
                    default: out_rdy = 1'($urandom_range(0, 1));
                endcase
                if (out_rdy && ena) got.push_back(int'(out));
                prev_stall = !(out_rdy && ena);
                prev_out = out;
            end else begin
                out_rdy = 1'b0;
                prev_stall = 1'b0;
            end
            @(negedge clk);
            cyc++;
        end
        ena = 1'b1;
        out_rdy = 1'b0;
        chk("sym_in_bound", cyc < BOUND, 1);
        chk("n_words", got.size(), exp_q.size());
        foreach (got[i]) if (i < exp_q.size()) chk("emit_word", got[i], exp_q[i]);
        chk("latency", cyc, STATE_W + 2 + exp_q.size() + emit_cyc + ena_low);
        chk("busy_idle", busy, 0);
        chk("err_state", err, m_err);
    endtask

    task automatic do_flush(input int rdy_mode);
        int cyc = 0;
        int lasts[$];
        int expw[$];
        for (int i = 0; i < NW; i++) expw.push_back((mx >> (SYM_W * i)) % (1 << SYM_W));
        flush_got.delete();
        @(negedge clk);
        chk("rdy_before_flush", in_rdy, 1);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        chk("busy_flush", busy, 1);
        chk("rdy_in_flush", in_rdy, 0);
        while (!in_rdy && cyc < BOUND) begin
            if (out_vld) begin
                out_rdy = (rdy_mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
                if (out_rdy) begin
                    flush_got.push_back(int'(out));
                    lasts.push_back(int'(out_last));
                end
            end else begin
                out_rdy = 1'b0;
            end
            @(negedge clk);
            cyc++;
        end
        out_rdy = 1'b0;
        chk("flush_in_bound", cyc < BOUND, 1);
        chk("flush_n_words", flush_got.size(), NW);
        foreach (flush_got[i]) if (i < NW) begin
            chk("flush_word", flush_got[i], expw[i]);
            chk("flush_last", lasts[i], (i == NW - 1) ? 1 : 0);
        end
        chk("vld_after_flush", out_vld, 0);
        chk("last_after_flush", out_last, 0);
        chk("busy_after_flush", busy, 0);
        mx = L;
    endtask

    task automatic chk_flush_lit(input string tag, input int w0, input int w1, input int w2, input int w3);
        int w[4] = '{w0, w1, w2, w3};
        for (int i = 0; i < 4 && i < flush_got.size(); i++) chk(tag, flush_got[i], w[i]);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        check_reset("rst");
        rst_n = 1'b1;

        send(128, 0, 0, 0);
        send(16, 200, 0, 0);
        do_flush(0);
        chk_flush_lit("flush_20c8", 'h8, 'hC, 'h0, 'h2);

        send(128, 0, 0, 0);
        send(16, 200, 1, 0);
        do_flush(0);
        chk_flush_lit("flush_stalled", 'h8, 'hC, 'h0, 'h2);
        send(128, 0, 0, 5);
        do_flush(0);
        chk_flush_lit("flush_ena", 'h0, 'h0, 'h0, 'h2);

        send(128, 0, 0, 0);
        send(0, 0, 0, 0);
        repeat (3) @(negedge clk);
        chk("no_out_f0", out_vld, 0);
        send(256, 0, 0, 0);
        do_flush(0);
        chk_flush_lit("flush_f0_fm", 'h0, 'h0, 'h0, 'h2);
        chk("err_sticky", err, 1);

        // Reset in the middle of a divide.
        @(negedge clk);
        s_count = CNT_W'(128);
        s_cumulative = '0;
        in_vld = 1'b1;
        @(negedge clk);
        in_vld = 1'b0;
        repeat (6) @(negedge clk);
        chk("busy_mid_div", busy, 1);
        #2 rst_n = 1'b0;
        #1 check_reset("rst_div");
        @(negedge clk);
        rst_n = 1'b1;
        mx = L;
        m_err = 1'b0;

        // Reset while the second flush word is on the output.
        send(128, 0, 0, 0);
        @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        out_rdy = 1'b1;
        @(negedge clk);
        out_rdy = 1'b0;
        chk("flush_w2_vld", out_vld, 1);
        chk("flush_w2_last", out_last, 0);
        #2 rst_n = 1'b0;
        #1 check_reset("rst_flush");
        @(negedge clk);
        rst_n = 1'b1;
        mx = L;

        send(128, 0, 0, 0);
        do_flush(0);
        chk_flush_lit("flush_after_rst", 'h0, 'h0, 'h0, 'h2);

        for (int k = 0; k < 40; k++) begin
            int f;
            int c;
            f = $urandom_range(1, M);
            c = $urandom_range(0, M - f);
            send(f, c, 2, 0);
            if (k % 8 == 7) do_flush(1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL timeout: simulation did not finish, %0d compared", n_cmp);
        $fatal(1, "timeout");
    end

endmodule
